// File: rtl/inst_queue_if.sv
//------------------------------------------------------------------------------
// inst_queue_if : fetch-side push / decode-side pop bundle of the instruction queue
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface inst_queue_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
);
  logic                   push_valid;
  logic                   push_ready;
  logic [ADDR_W-1:0]      push_pc;
  logic [INST_W-1:0]      push_inst;
  logic                   pop_valid;
  logic                   pop_ready;
  logic [ADDR_W-1:0]      pop_pc;
  logic [INST_W-1:0]      pop_inst;
  logic                   flush;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;

  modport master (
    output push_valid, push_pc, push_inst, pop_ready, flush,
    input  push_ready, pop_valid, pop_pc, pop_inst, count, full, empty
  );

  modport slave (
    input  push_valid, push_pc, push_inst, pop_ready, flush,
    output push_ready, pop_valid, pop_pc, pop_inst, count, full, empty
  );
endinterface

`default_nettype wire

// File: rtl/inst_queue.sv
//------------------------------------------------------------------------------
// inst_queue : elastic {pc, inst} FIFO between fetch and if_id, single-cycle flush.
// Optional macro IQ_BYPASS_EN adds a zero-latency path when the queue is empty.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inst_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst,
  inst_queue_if.slave  bus
);
  localparam int                 c_IDX_W   = $clog2(DEPTH);
  localparam int                 c_PTR_W   = c_IDX_W + 1;
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = {{(c_PTR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0]  r_pcMem   [DEPTH];
  logic [INST_W-1:0]  r_instMem [DEPTH];
  logic [c_PTR_W-1:0] r_wrPtr, r_rdPtr, r_count;
  logic               r_full, r_empty;

  logic [c_PTR_W-1:0] w_wrNext, w_rdNext, w_countNext;
  logic [c_IDX_W-1:0] w_wrIdx, w_rdIdx;
  logic               w_pushReady, w_popValid, w_bypass;
  logic               w_pushFire, w_popFire, w_passThru, w_doWrite, w_doRead;
  logic [ADDR_W-1:0]  w_popPc;
  logic [INST_W-1:0]  w_popInst;

  assign w_wrIdx = r_wrPtr[c_IDX_W-1:0];
  assign w_rdIdx = r_rdPtr[c_IDX_W-1:0];

  // rst gates the handshakes so everything reads idle while reset is held
  assign w_pushReady = rst & ~r_full & ~bus.flush;
`ifdef IQ_BYPASS_EN
  assign w_bypass    = rst & r_empty & bus.push_valid & ~bus.flush;
`else
  assign w_bypass    = 1'b0;
`endif
  assign w_popValid  = rst & ~bus.flush & (~r_empty | w_bypass);

  assign w_pushFire = bus.push_valid & w_pushReady;
  assign w_popFire  = w_popValid & bus.pop_ready;
  assign w_passThru = w_bypass & bus.pop_ready;
  assign w_doWrite  = w_pushFire & ~w_passThru;
  assign w_doRead   = w_popFire & ~w_passThru;

  always_comb begin
    w_wrNext    = r_wrPtr;
    w_rdNext    = r_rdPtr;
    w_countNext = r_count;
    if (bus.flush) begin
      w_wrNext    = '0;
      w_rdNext    = '0;
      w_countNext = '0;
    end else begin
      if (w_doWrite) w_wrNext = r_wrPtr + c_PTR_ONE;
      if (w_doRead)  w_rdNext = r_rdPtr + c_PTR_ONE;
      case ({w_doWrite, w_doRead})
        2'b10:   w_countNext = r_count + c_PTR_ONE;
        2'b01:   w_countNext = r_count - c_PTR_ONE;
        default: w_countNext = r_count;
      endcase
    end
  end

  always_comb begin
    w_popPc   = '0;
    w_popInst = '0;
    if (w_popValid) begin
`ifdef IQ_BYPASS_EN
      if (r_empty) begin
        w_popPc   = bus.push_pc;
        w_popInst = bus.push_inst;
      end else
`endif
      begin
        w_popPc   = r_pcMem[w_rdIdx];
        w_popInst = r_instMem[w_rdIdx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        r_pcMem[i]   <= '0;
        r_instMem[i] <= '0;
      end
    end else begin
      r_wrPtr <= w_wrNext;
      r_rdPtr <= w_rdNext;
      r_count <= w_countNext;
      // Same slot with opposite wrap bits means the writer is a full lap ahead
      r_full  <= (w_wrNext[c_IDX_W-1:0] == w_rdNext[c_IDX_W-1:0]) &&
                 (w_wrNext[c_IDX_W] != w_rdNext[c_IDX_W]);
      r_empty <= (w_wrNext == w_rdNext);
      if (w_doWrite) begin
        r_pcMem[w_wrIdx]   <= bus.push_pc;
        r_instMem[w_wrIdx] <= bus.push_inst;
      end
    end
  end

  assign bus.push_ready = w_pushReady;
  assign bus.pop_valid  = w_popValid;
  assign bus.pop_pc     = w_popPc;
  assign bus.pop_inst   = w_popInst;
  assign bus.count      = r_count;
  assign bus.full       = r_full;
  assign bus.empty      = r_empty;
endmodule

`default_nettype wire

// File: doc/inst_queue.md
# inst_queue

Parametrised instruction fetch queue between the fetch stage and the if_id pipeline register. It buffers {pc, inst} pairs so that fetch can run ahead of a stalled decode stage. It also discards all buffered fetches in one cycle on a branch or flush. Depth, address width and instruction width are parameters. It is the elastic successor of the fixed single-entry IF→ID hand-off.

## Interface
Parameters:
- ADDR_W, 32, width of the pc field
- INST_W, 32, width of the instruction field
- DEPTH, 4, number of entries; power of two, ≥ 2

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- push_valid  input  1  fetch presents a valid {push_pc, push_inst}
- push_ready  output  1  queue accepts a push this cycle
- push_pc  input  ADDR_W  pc of the fetched instruction
- push_inst  input  INST_W  fetched instruction
- pop_valid  output  1  head entry valid
- pop_ready  input  1  decode consumes the head this cycle
- pop_pc  output  ADDR_W  head pc; 0 when pop_valid=0
- pop_inst  output  INST_W  head instruction; 0 when pop_valid=0
- flush  input  1  synchronous discard of all entries
- count  output  $clog2(DEPTH)+1  registered occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0

## Operation
- Storage is a circular buffer of DEPTH entries.
- Read and write pointers are each $clog2(DEPTH)+1 bits. The MSB is a wrap bit.
  - full: addresses equal and wrap bits differ.
  - empty: pointers fully equal.
- Push handshake is push_valid & push_ready.
  - push_ready = !full & !flush.
  - push_ready has no combinational dependence on pop_ready.
- Pop handshake is pop_valid & pop_ready.
  - pop_valid = !empty & !flush, except for the bypass case under Configuration.
- Push writes the entry at the write pointer. Pop advances the read pointer.
- Push and pop in the same cycle: both occur and count is unchanged.
- flush has priority over push and pop.
  - On the next edge both pointers go to 0 and count goes to 0.
  - Any push_valid in the flush cycle is discarded.
  - No pop handshake can occur in a flush cycle.
- Pointer wrap-around is natural modulo 2·DEPTH. No entry is ever overwritten while occupied.
- Asynchronous reset (rst=0) takes effect immediately, including mid-operation, and holds while rst=0:
  - pointers = 0, count = 0, empty = 1, full = 0
  - push_ready = 0, pop_valid = 0, pop_pc = 0, pop_inst = 0
  - all storage entries = 0
- After rst deasserts, push_ready = 1 in the first cycle.

## Timing
- count, full and empty are registered and updated on the edge after the handshake.
- pop_pc and pop_inst are driven from storage indexed by the registered read pointer. There is no extra output register.
- Latency without bypass: a push accepted at edge N gives pop_valid=1 during cycle N+1.
- Full: push_ready=0. A pop at edge N gives push_ready=1 during cycle N+1.
- Empty with push_valid and pop_ready both high (no bypass): only the push occurs. count becomes 1 at the next edge.
- Flush at edge N: during cycle N+1, empty=1, count=0 and pop_valid=0. A push is accepted again in cycle N+1.
- Sustained throughput is one push and one pop per cycle when 0 < count < DEPTH.

## Configuration
- Macro IQ_BYPASS_EN.
- Defined: when empty=1, push_valid=1 and flush=0:
  - pop_valid=1, and pop_pc/pop_inst equal push_pc/push_inst combinationally.
  - If pop_ready=1, the entry goes straight through. It is not written and count stays 0.
  - If pop_ready=0, the entry is written normally and count becomes 1.
  - Zero-cycle latency when the queue is empty.
- Not defined: no path from push inputs to pop outputs. Minimum latency is one cycle, as under Timing.

## Test plan
- Reset mid-stream: fill 3 entries, pull rst low → all outputs immediately read 0, except empty=1. After release, count=0 and push_ready=1.
- Fill/drain, DEPTH=4: push pc 0x00,0x04,0x08,0x0C with pop_ready=0.
  - Expect count=4, full=1, push_ready=0; a fifth push is not accepted.
  - Then pop 4 times: pop_pc order is 0x00,0x04,0x08,0x0C, then empty=1.
- Wrap-around: stream 10 pushes with concurrent pops (pc 0x100+4k) → pop_pc sequence strictly in order, with count constant at 1 after the first cycle.
- Flush priority: with count=3, assert flush together with push_valid (pc 0x200) and pop_ready.
  - No pop handshake occurs during the flush cycle.
  - Next cycle: count=0 and pop_valid=0; 0x200 never appears at the output.
- Full with simultaneous pop: at count=4, pop and push_valid in the same cycle → only the pop occurs. count=3 next cycle, then the push is accepted.
- Bypass:
  - IQ_BYPASS_EN defined: empty queue, push pc 0x300 with pop_ready=1 → pop_valid=1 and pop_pc=0x300 in the same cycle, count stays 0.
  - Without the macro: pop_valid=0 that cycle, and pop_pc=0x300 appears the next cycle.
